div_ctrl: RTL and testbench

- Front-end sequencer directly upstream of the iterative unsigned non-restoring divider core (div) in the multdiv unit.
- Accepts a one-cycle signed division request and captures the operands, then presents the operands' magnitudes to the core, holding them stable for the whole iteration.
- Launches the core, waits for its ready flag, then applies the sign correction and returns a registered signed quotient with a one-cycle ready pulse.
- Also short-circuits divide-by-zero and guards against a hung core with a watchdog.

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/twos_neg.sv | 13 +
 rtl/div_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: divider sequencer state encoding
// and default sizing.
package multdiv_pkg;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FIXUP  = 2'd3
  } state_t;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate: passes the input through, or returns
// its negation modulo 2^WIDTH when enabled.
module twos_neg #(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_en ? (~i_in + WIDTH'(1)) : i_in;

endmodule

// File: rtl/div_ctrl.sv
// Signed front-end for the unsigned iterative divider core: captures a
// request, feeds operand magnitudes to the core, waits for its ready flag
// (with a watchdog), then sign-corrects and returns a registered quotient.
module div_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = multdiv_pkg::WIDTH,
  parameter int TIMEOUT = multdiv_pkg::TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [WIDTH-1:0] core_operandA,
  output logic [WIDTH-1:0] core_operandB,
  output logic             core_start,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_resultRDY
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mag_a, r_mag_b, r_quot, r_result;
  logic             r_sign_q, r_zero_b, r_timeout, r_exception, r_rdy;
  logic [CW-1:0]    r_wd_cnt, w_wd_inc;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_fixed;
  logic             w_zero_b, w_accept, w_expire, w_deliver;

  // Magnitudes of the incoming operands and the sign-corrected quotient.
  twos_neg #(.WIDTH(WIDTH)) u_neg_a (
    .i_in (data_operandA),
    .i_en (data_operandA[WIDTH-1]),
    .o_out(w_mag_a)
  );

  twos_neg #(.WIDTH(WIDTH)) u_neg_b (
    .i_in (data_operandB),
    .i_en (data_operandB[WIDTH-1]),
    .o_out(w_mag_b)
  );

  twos_neg #(.WIDTH(WIDTH)) u_neg_q (
    .i_in (r_quot),
    .i_en (r_sign_q),
    .o_out(w_fixed)
  );

  assign w_zero_b       = (data_operandB == '0);
  assign w_wd_inc       = r_wd_cnt + CW'(1);
  assign busy           = (r_state != IDLE);
  assign core_start     = (r_state == LAUNCH);
  assign core_operandA  = r_mag_a;
  assign core_operandB  = r_mag_b;
  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode plus one-cycle strobes for the datapath.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    w_next    = r_state;
    w_accept  = 1'b0;
    w_expire  = 1'b0;
    w_deliver = 1'b0;
    case (r_state)
      IDLE:   ;
      LAUNCH: w_next = WAIT;
      WAIT: begin
        // The core's ready flag is stale in the first WAIT cycle (count 0).
        if ((r_wd_cnt != '0) && core_resultRDY) begin
          w_accept = 1'b1;
          w_next   = FIXUP;
        end else if (w_wd_inc == CW'(TIMEOUT)) begin
          w_expire = 1'b1;
          w_next   = FIXUP;
        end
      end
      FIXUP: begin
        w_deliver = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // A new request always wins and silently aborts any operation in flight.
    if (ctrl_DIV) begin
      w_next    = w_zero_b ? FIXUP : LAUNCH;
      w_accept  = 1'b0;
      w_expire  = 1'b0;
      w_deliver = 1'b0;
    end
  end

  // Operand capture, watchdog, quotient capture and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_sign_q    <= 1'b0;
      r_zero_b    <= 1'b0;
      r_timeout   <= 1'b0;
      r_quot      <= '0;
      r_wd_cnt    <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= w_deliver;
      if (ctrl_DIV) begin
        r_sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_mag_a   <= w_mag_a;
        r_mag_b   <= w_mag_b;
        r_zero_b  <= w_zero_b;
        r_timeout <= 1'b0;
      end
      if (r_state == LAUNCH)    r_wd_cnt <= '0;
      else if (r_state == WAIT) r_wd_cnt <= w_wd_inc;
      if (w_accept) r_quot    <= core_result;
      if (w_expire) r_timeout <= 1'b1;
      if (w_deliver) begin
        r_result    <= (r_zero_b | r_timeout) ? '0 : w_fixed;
        r_exception <= r_zero_b | r_timeout;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl: a behavioural stub core with programmable
// latency (and a stale ready flag right after start) plus a signed-division
// reference model computed with plain 64-bit arithmetic.
module tb_div_ctrl;

  localparam int W       = 32;
  localparam int TIMEOUT = 48;

  logic         clock;
  logic         reset_n;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA, data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
  logic [W-1:0] core_operandA, core_operandB;
  logic         core_start;
  logic [W-1:0] core_result;
  logic         core_resultRDY;

  int n_checks = 0;
  int n_errors = 0;

  int stub_lat  = 1;
  bit stub_hang = 1'b0;

  div_ctrl #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy),
    .core_operandA (core_operandA),
    .core_operandB (core_operandB),
    .core_start    (core_start),
    .core_result   (core_result),
    .core_resultRDY(core_resultRDY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: signed quotient truncated toward zero, modulo 2^W.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    return s[W-1:0];
  endfunction

  // Stub core: on start it holds its previous (stale) ready/result through
  // the first WAIT cycle, then drops ready for stub_lat cycles and raises it
  // with the unsigned quotient; in hang mode ready never comes back.
  initial begin
    int          s_cnt;
    bit          s_stale;
    logic [W-1:0] s_q;
    s_cnt = 0; s_stale = 1'b0; s_q = '0;
    core_result    = 32'hDEAD_BEEF;
    core_resultRDY = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        s_cnt = 0; s_stale = 1'b0;
      end else if (core_start) begin
        s_q     = (core_operandB == '0) ? '1 : core_operandA / core_operandB;
        s_stale = 1'b1;
        s_cnt   = stub_lat;
      end else if (s_stale) begin
        s_stale = 1'b0;
      end else if (s_cnt > 0) begin
        core_resultRDY = 1'b0;
        s_cnt--;
        if (s_cnt == 0 && !stub_hang) begin
          core_resultRDY = 1'b1;
          core_result    = s_q;
        end
      end
    end
  end

  // One complete division, issued at the current negedge; returns at the
  // negedge of the ready pulse (an IDLE cycle, so the next call is back-to-back).
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit hang);
    int           n, starts, exp_n, exp_starts;
    bit           held;
    logic [W-1:0] exp_q;
    bit           exp_exc;
    stub_lat      = lat;
    stub_hang     = hang;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    n = 1; starts = 0; held = 1'b1;
    check({tag, " rdy_low_after_req"}, data_resultRDY, 1'b0);
    while (!data_resultRDY && n < 200) begin
      if (core_start) starts++;
      if (!busy || core_operandA !== ref_mag(a) || core_operandB !== ref_mag(b)) held = 1'b0;
      @(negedge clock);
      n++;
    end
    if (b == '0) begin
      exp_q = '0; exp_exc = 1'b1; exp_n = 2; exp_starts = 0;
    end else if (hang) begin
      exp_q = '0; exp_exc = 1'b1; exp_n = 3 + TIMEOUT; exp_starts = 1;
    end else begin
      exp_q = ref_quot(a, b); exp_exc = 1'b0; exp_n = 4 + lat; exp_starts = 1;
    end
    check({tag, " latency"},   n,              exp_n);
    check({tag, " result"},    data_result,    exp_q);
    check({tag, " exception"}, data_exception, exp_exc);
    check({tag, " starts"},    starts,         exp_starts);
    check({tag, " held_ops"},  held,           1'b1);
    check({tag, " idle_at_rdy"}, busy,         1'b0);
  endtask

  logic [W-1:0] dir_a [6] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'h8000_0000};
  logic [W-1:0] dir_b [6] = '{32'd7,   32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF};

  initial begin
    logic [W-1:0] ra, rb, last_res;
    bit           last_exc;
    int           pulses;
    ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    reset_n  = 1'b1;
    #3 reset_n = 1'b0;
    #2;
    check("reset result",    data_result,    '0);
    check("reset exception", data_exception, 1'b0);
    check("reset rdy",       data_resultRDY, 1'b0);
    check("reset busy",      busy,           1'b0);
    check("reset start",     core_start,     1'b0);
    check("reset opA",       core_operandA,  '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases: signs, divide-by-zero, most-negative / -1.
    for (int i = 0; i < 6; i++) run_div($sformatf("dir%0d", i), dir_a[i], dir_b[i], 10, 1'b0);

    // Randomized operands, divisor zeros and core latencies.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(8, 31);
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_div($sformatf("rnd%0d", i), ra, rb, $urandom_range(1, 40), 1'b0);
    end

    // Abort: a second request 10 cycles into WAIT replaces the first.
    stub_lat = 30; stub_hang = 1'b0;
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (10) @(negedge clock);
    check("abort in_wait busy", busy, 1'b1);
    check("abort in_wait opA",  core_operandA, 32'd100);
    stub_lat = 5;
    ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    pulses = 0; last_res = '0; last_exc = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (data_resultRDY) begin
        pulses++;
        last_res = data_result;
        last_exc = data_exception;
      end
      @(negedge clock);
    end
    check("abort pulses",    pulses,   1);
    check("abort result",    last_res, 32'd3);
    check("abort exception", last_exc, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    stub_lat = 30;
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset busy",   busy,           1'b0);
    check("midreset start",  core_start,     1'b0);
    check("midreset result", data_result,    '0);
    check("midreset exc",    data_exception, 1'b0);
    check("midreset rdy",    data_resultRDY, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Hung core: watchdog aborts, then a normal division still works.
    run_div("timeout", 32'd100, 32'd7, 1, 1'b1);
    run_div("recover", 32'hFFFF_FF9C, 32'd7, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
